// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_control_fsm
// Brief   : RV32 multicycle control FSM with a memory-wait watchdog.
//           Optional LUI/AUIPC support is enabled by defining UTYPE_SUPPORT_EN.
// Revision: 1.0
// ============================================================================
module multicycle_control_fsm #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] INSTRUCTION,
  input  logic        ZERO,
  input  logic        MEM_READY,
  output logic        MEM_REQ,
  output logic [2:0]  IMMSRC,
  output logic        PCWRITE,
  output logic        IRWRITE,
  output logic        MEMWRITE,
  output logic        REGWRITE,
  output logic        ADRSRC,
  output logic [1:0]  ALUSRCA,
  output logic [1:0]  ALUSRCB,
  output logic [1:0]  RESULTSRC,
  output logic [1:0]  ALUOP,
  output logic        ERROR,
  output logic [3:0]  STATE
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
`ifdef UTYPE_SUPPORT_EN
    S_UTYPE    = 4'd11,
`endif
    S_ERR      = 4'd15
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       wait_state;
  logic       wait_expired;
  logic       unused_instr;

  assign opcode       = INSTRUCTION[6:0];
  assign funct3       = INSTRUCTION[14:12];
  assign unused_instr = ^{INSTRUCTION[31:15], INSTRUCTION[11:7]};

  // This is the last allowed cycle of the current memory wait.
  assign wait_expired = (wait_cnt_q == CW'(MEM_WAIT_MAX - 1));

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_state = 1'b0;
    MEM_REQ    = 1'b0;
    ADRSRC     = 1'b0;
    PCWRITE    = 1'b0;
    IRWRITE    = 1'b0;
    MEMWRITE   = 1'b0;
    REGWRITE   = 1'b0;
    ALUSRCA    = 2'b00;
    ALUSRCB    = 2'b00;
    RESULTSRC  = 2'b00;
    ALUOP      = 2'b00;
    ERROR      = 1'b0;

    case (opcode)
      OP_LOAD, OP_IMM:   IMMSRC = 3'b000;
      OP_STORE:          IMMSRC = 3'b001;
      OP_BRANCH:         IMMSRC = 3'b010;
      OP_JAL:            IMMSRC = 3'b011;
      OP_LUI, OP_AUIPC:  IMMSRC = 3'b100;
      default:           IMMSRC = 3'b000;
    endcase

    case (state_q)
      S_FETCH: begin
        wait_state = 1'b1;
        MEM_REQ    = 1'b1;
        ALUSRCB    = 2'b10;
        RESULTSRC  = 2'b10;
        if (MEM_READY) begin
          IRWRITE = 1'b1;
          PCWRITE = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        ALUSRCA = 2'b01;
        ALUSRCB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_REG:            state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
`ifdef UTYPE_SUPPORT_EN
          OP_LUI, OP_AUIPC:  state_d = S_UTYPE;
`endif
          default:           state_d = S_ERR;
        endcase
      end
      S_MEMADR: begin
        ALUSRCA = 2'b10;
        ALUSRCB = 2'b01;
        state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD, S_MEMWRITE: begin
        wait_state = 1'b1;
        MEM_REQ    = 1'b1;
        ADRSRC     = 1'b1;
        MEMWRITE   = (state_q == S_MEMWRITE);
        if (MEM_READY) begin
          state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
        end else if (wait_expired) begin
          state_d = S_ERR;
        end
      end
      S_MEMWB: begin
        RESULTSRC = 2'b01;
        REGWRITE  = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSRCA = 2'b10;
        ALUSRCB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUOP   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        REGWRITE = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSRCA = 2'b10;
        ALUOP   = 2'b01;
        case (funct3)
          3'b000:  PCWRITE = ZERO;
          3'b001:  PCWRITE = ~ZERO;
          default: PCWRITE = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      S_JAL: begin
        PCWRITE = 1'b1;
        ALUSRCA = 2'b01;
        ALUSRCB = 2'b10;
        state_d = S_ALUWB;
      end
`ifdef UTYPE_SUPPORT_EN
      S_UTYPE: begin
        ALUSRCA = (opcode == OP_AUIPC) ? 2'b01 : 2'b00;
        ALUSRCB = 2'b01;
        ALUOP   = 2'b11;
        state_d = S_ALUWB;
      end
`endif
      S_ERR: begin
        ERROR = 1'b1;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase

    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (wait_state) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end else begin
      wait_cnt_d = '0;
    end

    // Reset suppresses every strobe combinationally, even before the edge lands.
    if (!RESET_N) begin
      PCWRITE  = 1'b0;
      IRWRITE  = 1'b0;
      MEMWRITE = 1'b0;
      REGWRITE = 1'b0;
    end
    STATE = RESET_N ? state_q : 4'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// Testbench for multicycle_control_fsm: directed scenarios plus randomized
// instruction streams checked every cycle against an instruction-level model.
module tb_multicycle_control_fsm;

  localparam int MEM_WAIT_MAX = 15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic [31:0] INSTRUCTION;
  logic        ZERO;
  logic        MEM_READY;
  logic        MEM_REQ;
  logic [2:0]  IMMSRC;
  logic        PCWRITE, IRWRITE, MEMWRITE, REGWRITE, ADRSRC;
  logic [1:0]  ALUSRCA, ALUSRCB, RESULTSRC, ALUOP;
  logic        ERROR;
  logic [3:0]  STATE;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .CLK(clk), .RESET_N(RESET_N), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
    .MEM_READY(MEM_READY), .MEM_REQ(MEM_REQ), .IMMSRC(IMMSRC),
    .PCWRITE(PCWRITE), .IRWRITE(IRWRITE), .MEMWRITE(MEMWRITE),
    .REGWRITE(REGWRITE), .ADRSRC(ADRSRC), .ALUSRCA(ALUSRCA),
    .ALUSRCB(ALUSRCB), .RESULTSRC(RESULTSRC), .ALUOP(ALUOP),
    .ERROR(ERROR), .STATE(STATE)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       err, req, adr, pcw, irw, mw, rw;
    logic [2:0] imm;
    logic [1:0] a, b, r, op;
  } out_t;

  out_t act;
  assign act = {STATE, ERROR, MEM_REQ, ADRSRC, PCWRITE, IRWRITE, MEMWRITE,
                REGWRITE, IMMSRC, ALUSRCA, ALUSRCB, RESULTSRC, ALUOP};

  // Model: the remaining state path of the current instruction, with memory waits.
  int m_state = -1;
  int m_cnt   = 0;
  int m_plan[$];

  function automatic bit is_wait(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM:  return 3'b000;
      OP_STORE:         return 3'b001;
      OP_BRANCH:        return 3'b010;
      OP_JAL:           return 3'b011;
      OP_LUI, OP_AUIPC: return 3'b100;
      default:          return 3'b000;
    endcase
  endfunction

  function void set_plan(input logic [6:0] op);
    case (op)
      OP_LOAD:   m_plan = '{2, 3, 4};
      OP_STORE:  m_plan = '{2, 5};
      OP_REG:    m_plan = '{6, 8};
      OP_IMM:    m_plan = '{7, 8};
      OP_BRANCH: m_plan = '{9};
      OP_JAL:    m_plan = '{10, 8};
`ifdef UTYPE_SUPPORT_EN
      OP_LUI, OP_AUIPC: m_plan = '{11, 8};
`endif
      default:   m_plan = '{15};
    endcase
  endfunction

  task automatic model_step();
    if (!RESET_N) begin
      m_state = 0;
      m_cnt   = 0;
      m_plan  = {};
    end else if (m_state < 0 || m_state == 15) begin
      m_cnt = 0;
    end else if (is_wait(m_state) && !MEM_READY) begin
      if (m_cnt + 1 >= MEM_WAIT_MAX) begin
        m_state = 15;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      if (m_state == 1) set_plan(INSTRUCTION[6:0]);
      m_cnt = 0;
      if (m_state == 0)             m_state = 1;
      else if (m_plan.size() == 0)  m_state = 0;
      else                          m_state = m_plan.pop_front();
    end
  endtask

  function automatic void expect_outputs(output out_t e, output out_t m);
    logic [6:0] op;
    logic [2:0] f3;
    op = INSTRUCTION[6:0];
    f3 = INSTRUCTION[14:12];
    e = '0;
    m = '0;
    e.imm = imm_of(op);
    m.imm = '1;
    if (!RESET_N) begin
      m.st = '1; m.pcw = 1'b1; m.irw = 1'b1; m.mw = 1'b1; m.rw = 1'b1;
      return;
    end
    if (m_state < 0) return;
    m.st = '1; m.pcw = 1'b1; m.irw = 1'b1; m.mw = 1'b1; m.rw = 1'b1;
    m.err = 1'b1; m.req = 1'b1;
    e.st  = 4'(m_state);
    e.err = (m_state == 15);
    e.req = is_wait(m_state);
    case (m_state)
      0: begin
        m.adr = 1'b1;
        if (MEM_READY) begin
          e.pcw = 1'b1; e.irw = 1'b1; e.b = 2'b10; e.r = 2'b10;
          m.a = '1; m.b = '1; m.r = '1;
        end
      end
      1: begin e.a = 2'b01; e.b = 2'b01; m.a = '1; m.b = '1; m.op = '1; end
      2: begin e.a = 2'b10; e.b = 2'b01; m.a = '1; m.b = '1; m.op = '1; end
      3: begin e.adr = 1'b1; m.adr = 1'b1; end
      4: begin e.r = 2'b01; e.rw = 1'b1; m.r = '1; end
      5: begin e.adr = 1'b1; m.adr = 1'b1; e.mw = 1'b1; end
      6: begin e.a = 2'b10; e.op = 2'b10; m.a = '1; m.b = '1; m.op = '1; end
      7: begin e.a = 2'b10; e.b = 2'b01; e.op = 2'b10; m.a = '1; m.b = '1; m.op = '1; end
      8: begin e.rw = 1'b1; m.r = '1; end
      9: begin
        e.a = 2'b10; e.op = 2'b01; m.a = '1; m.b = '1; m.op = '1;
        e.pcw = ((f3 == 3'b000) && ZERO) || ((f3 == 3'b001) && !ZERO);
      end
      10: begin e.pcw = 1'b1; e.a = 2'b01; e.b = 2'b10; m.a = '1; m.b = '1; m.op = '1; end
      11: begin
        e.a = (op == OP_AUIPC) ? 2'b01 : 2'b00; e.b = 2'b01; e.op = 2'b11;
        m.a = '1; m.b = '1; m.op = '1;
      end
      default: ;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin
    out_t e, m;
    forever begin
      @(negedge clk);
      expect_outputs(e, m);
      checks++;
      if (((act ^ e) & m) !== '0) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t model_state=%0d actual=%h required=%h mask=%h",
                 $time, m_state, act, e, m);
      end
    end
  end

  task automatic chk(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [8];
    logic [31:0] w;
    int          k;
    ops = '{OP_LOAD, OP_STORE, OP_REG, OP_IMM, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC};
    w = $urandom;
    k = $urandom_range(0, 8);
    if (k < 8) w[6:0] = ops[k];
    if (w[6:0] == OP_BRANCH) w[14:12] = 3'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    int pct;
    RESET_N = 1'b0; INSTRUCTION = '0; ZERO = 1'b0; MEM_READY = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    RESET_N = 1'b1;

    // add x1,x2,x3
    INSTRUCTION = 32'h003100B3; MEM_READY = 1'b1;
    sample(); chk("reset_state", STATE, 0); chk("reset_error", ERROR, 0);
    chk("add_irwrite", IRWRITE, 1);
    next(); sample(); chk("add_decode", STATE, 1);
    next(); sample(); chk("add_execr", STATE, 6); chk("add_execr_regwrite", REGWRITE, 0);
    next(); sample(); chk("add_aluwb", STATE, 8); chk("add_aluwb_regwrite", REGWRITE, 1);
    next();

    // lw with three MEM_READY=0 cycles in MEMREAD
    INSTRUCTION = 32'h00012083; MEM_READY = 1'b1;
    sample(); chk("lw_fetch", STATE, 0);
    next(); next(); next();
    MEM_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample(); chk("lw_wait", STATE, 3); chk("lw_immsrc", IMMSRC, 0);
      next();
    end
    MEM_READY = 1'b1;
    sample(); chk("lw_ready", STATE, 3);
    next(); sample(); chk("lw_memwb", STATE, 4);
    next();

    // beq taken then not taken
    INSTRUCTION = 32'h00000063; ZERO = 1'b1;
    sample(); chk("beq1_fetch", STATE, 0);
    next(); next(); sample();
    chk("beq1_state", STATE, 9); chk("beq1_pcwrite", PCWRITE, 1); chk("beq_immsrc", IMMSRC, 2);
    next();
    ZERO = 1'b0;
    sample(); chk("beq2_fetch", STATE, 0);
    next(); next(); sample();
    chk("beq2_state", STATE, 9); chk("beq2_pcwrite", PCWRITE, 0);
    next();

    // MEM_READY stuck low in FETCH
    INSTRUCTION = 32'h003100B3; MEM_READY = 1'b0;
    repeat (MEM_WAIT_MAX - 1) next();
    sample(); chk("stuck_last_fetch", STATE, 0);
    next(); sample();
    chk("stuck_err_state", STATE, 15); chk("stuck_error", ERROR, 1); chk("stuck_mem_req", MEM_REQ, 0);
    next(); RESET_N = 1'b0;
    next(); RESET_N = 1'b1;
    sample(); chk("stuck_reset_state", STATE, 0); chk("stuck_reset_error", ERROR, 0);
    next();

    // lui
    INSTRUCTION = 32'h123450B7; MEM_READY = 1'b1;
    sample(); chk("lui_fetch", STATE, 0);
    next(); next(); sample();
    chk("lui_immsrc", IMMSRC, 4);
`ifdef UTYPE_SUPPORT_EN
    chk("lui_utype", STATE, 11);
    next(); sample(); chk("lui_aluwb", STATE, 8);
    next();
`else
    chk("lui_err", STATE, 15);
    next(); RESET_N = 1'b0;
    next(); RESET_N = 1'b1;
`endif

    // sw interrupted by reset in MEMWRITE
    INSTRUCTION = 32'h00112023; MEM_READY = 1'b1;
    sample(); chk("sw_fetch", STATE, 0);
    next(); next(); next();
    MEM_READY = 1'b0;
    sample(); chk("sw_memwrite_state", STATE, 5); chk("sw_memwrite_strobe", MEMWRITE, 1);
    next(); RESET_N = 1'b0; MEM_READY = 1'b1;
    sample(); chk("sw_reset_strobe", MEMWRITE, 0); chk("sw_reset_state", STATE, 0);
    next(); RESET_N = 1'b1;
    sample(); chk("sw_after_reset", STATE, 0);
    next();

    // Randomized instruction stream
    pct = 95;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (m_state == 15) RESET_N = 1'b0;
      else               RESET_N = ($urandom_range(0, 299) != 0);
      if (m_state == 0) begin
        INSTRUCTION = rand_instr();
        case ($urandom_range(0, 2))
          0:       pct = 95;
          1:       pct = 60;
          default: pct = 10;
        endcase
      end
      MEM_READY = ($urandom_range(0, 99) < pct);
      ZERO      = 1'($urandom_range(0, 1));
      next();
    end

    sample();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, meaning the maximum cycles spent waiting on MEM_READY in one memory state before the block declares an error.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port INSTRUCTION  input  32  latched instruction word; decoding uses opcode [6:0] and funct3 [14:12].
REQ-005 SHALL have port ZERO  input  1  ALU zero flag, sampled in BRANCH.
REQ-006 SHALL have port MEM_READY  input  1  memory completion strobe.
REQ-007 SHALL have port MEM_REQ  output  1  memory access request.
REQ-008 SHALL have port IMMSRC  output  3  extender select: I=000, S=001, B=010, J=011, U=100.
REQ-009 SHALL have ports PCWRITE, IRWRITE, MEMWRITE, REGWRITE, ADRSRC  output  1 each  datapath strobes and selects.
REQ-010 SHALL have ports ALUSRCA, ALUSRCB, RESULTSRC, ALUOP  output  2 each  datapath mux selects and ALU decoder class.
REQ-011 SHALL have ports ERROR  output  1 (sticky fault) and STATE  output  4 (current state code).

Function
REQ-012 SHALL implement the states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, UTYPE=11 and ERR=15.
REQ-013 SHALL, in FETCH, assert MEM_REQ with ADRSRC=0, and SHALL stay in FETCH while MEM_READY=0.
REQ-014 SHALL, in FETCH when MEM_READY=1, pulse IRWRITE and PCWRITE for one cycle, drive ALUSRCA=00, ALUSRCB=10 and RESULTSRC=10, and go to DECODE.
REQ-015 SHALL go from DECODE on opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 0110111 or 0010111 -> UTYPE (macro permitting); any other opcode -> ERR.
REQ-016 SHALL, in DECODE, drive ALUSRCA=01, ALUSRCB=01 and ALUOP=00, so that the branch target is computed.
REQ-017 SHALL drive IMMSRC combinationally from the opcode in every state: loads and OP-IMM -> 000, stores -> 001, branches -> 010, JAL -> 011, LUI/AUIPC -> 100, all others -> 000.
REQ-018 SHALL go from MEMADR to MEMREAD for a load and to MEMWRITE for a store, with ALUSRCA=10, ALUSRCB=01 and ALUOP=00 in MEMADR.
REQ-019 SHALL, in MEMREAD and MEMWRITE, hold MEM_REQ=1 and ADRSRC=1, and SHALL assert MEMWRITE only in MEMWRITE.
REQ-020 SHALL leave MEMREAD for MEMWB, and MEMWRITE for FETCH, only on MEM_READY=1.
REQ-021 SHALL, in MEMWB, drive RESULTSRC=01 and REGWRITE=1, then go to FETCH.
REQ-022 SHALL, in EXECR (ALUSRCA=10, ALUSRCB=00) and EXECI (ALUSRCA=10, ALUSRCB=01), drive ALUOP=10 and go to ALUWB.
REQ-023 SHALL, in ALUWB, drive RESULTSRC=00 and REGWRITE=1, then go to FETCH.
REQ-024 SHALL, in BRANCH, drive ALUSRCA=10, ALUSRCB=00 and ALUOP=01, and pulse PCWRITE when ZERO matches the condition: funct3 000 taken on ZERO=1, funct3 001 taken on ZERO=0.
REQ-025 SHALL treat any other funct3 in BRANCH as not taken, and SHALL go to FETCH after BRANCH.
REQ-026 SHALL, in JAL, pulse PCWRITE, drive ALUSRCA=01, ALUSRCB=10 and ALUOP=00, then go to ALUWB.
REQ-027 SHALL count cycles spent in FETCH, MEMREAD and MEMWRITE, clearing the count on every state change.
REQ-028 SHALL, when that count reaches MEM_WAIT_MAX with MEM_READY=0, go to ERR.
REQ-029 SHALL keep ERR absorbing: ERROR=1, every strobe 0 and MEM_REQ=0 until reset.
REQ-030 SHALL keep the strobes (PCWRITE, IRWRITE, MEMWRITE, REGWRITE) at 0 in every state not listed for them above.

Reset
REQ-031 SHALL, on RESET_N=0 at a clock edge, enter FETCH, clear the wait counter and clear ERROR.
REQ-032 SHALL hold every strobe at 0 and STATE at 0 during reset, with reset overriding any pending transition including one mid memory wait.

Configuration
REQ-033 SHALL, when UTYPE_SUPPORT_EN is defined, route LUI/AUIPC to UTYPE, which drives ALUSRCA=00 for LUI or 01 for AUIPC, ALUSRCB=01 and ALUOP=11, then goes to ALUWB.
REQ-034 SHALL, when UTYPE_SUPPORT_EN is undefined, omit UTYPE and send opcodes 0110111/0010111 to ERR.

Verification
REQ-035 SHALL cover: add x1,x2,x3 (0x003100B3) with MEM_READY=1 -> FETCH, DECODE, EXECR, ALUWB, FETCH; REGWRITE=1 only in ALUWB.
REQ-036 SHALL cover: lw (opcode 0000011) with MEM_READY held 0 for 3 cycles in MEMREAD -> state stays 3 for 3 cycles, MEMWB follows, IMMSRC=000.
REQ-037 SHALL cover: beq with ZERO=1, then with ZERO=0 -> PCWRITE pulses in BRANCH only for the first case; IMMSRC=010.
REQ-038 SHALL cover: MEM_READY stuck 0 in FETCH -> ERR after 15 cycles with ERROR=1, then RESET_N=0 for one edge -> STATE=0, ERROR=0.
REQ-039 SHALL cover: lui (0x123450B7) with and without UTYPE_SUPPORT_EN -> UTYPE then ALUWB with IMMSRC=100 when defined; ERR when undefined.
REQ-040 SHALL cover: RESET_N=0 asserted in MEMWRITE -> next state FETCH, MEMWRITE strobe 0 on that edge.
